sonar_ping_ctrl: RTL
====================

# sonar_ping_ctrl

Measurement sequencer for the Sonar-on-Chip receive chain. On each start request it drives the ultrasonic transmit burst, then blanks the receiver for a programmable window. It then listens on the comparator output (moving-average magnitude vs. threshold) and measures time of flight in clock cycles. It sits between the Wishbone register file (configuration, start/abort, result readback) and the PCM → amplify → abs → MAF → compare datapath, whose clock-enable it gates.

## Interface
- CNT_W, 32, width of time-of-flight counter, timeout and result
- DIV_W, 16, width of transmit half-period divider
- BURST_W, 8, width of burst period count
- DEB_W, 4, width of echo debounce length
- clk  in  1  system clock (wb_clk_i domain); one clock
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle measurement request
- abort_i  in  1  cancel the current measurement
- cfg_half_i  in  DIV_W  transmit half-period in cycles (0 treated as 1)
- cfg_burst_i  in  BURST_W  number of full transmit periods (0 = no burst)
- cfg_blank_i  in  CNT_W  blanking length in cycles
- cfg_tmo_i  in  CNT_W  listen timeout in cycles (0 treated as 1)
- cfg_deb_i  in  DEB_W  consecutive echo-high cycles required (0 treated as 1)
- echo_i  in  1  comparator output (compare_ch1_out)
- irq_clr_i  in  1  clears irq_o
- tx_o  out  1  transmit square wave
- dp_ce_o  out  1  datapath clock-enable, high only in LISTEN
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- tof_o  out  CNT_W  last time of flight; all-ones on timeout
- timeout_o  out  1  last measurement timed out
- irq_o  out  1  sticky completion interrupt

## Operation
- Reset: state IDLE; all outputs 0. tof_o = 0, internal counters = 0.
- States are IDLE, TX, BLANK, LISTEN and DONE.
- IDLE: when start_i = 1 and abort_i = 0, the block latches all cfg_* into shadow registers, clears the ToF counter to 0 and selects its next state:
  - TX if burst ≠ 0;
  - else BLANK if blank ≠ 0;
  - else LISTEN.
- start_i is ignored in every state except IDLE. cfg_* changes after acceptance have no effect.
- ToF counter: 0 on the first cycle after acceptance. It increments by 1 each cycle in TX, BLANK and LISTEN, and saturates at all-ones.
- TX:
  - tx_o = 1 on the first TX cycle and toggles every half cycles.
  - After 2·burst half-periods, tx_o returns to 0 and the block goes to BLANK (or to LISTEN if blank = 0).
- BLANK: lasts exactly blank cycles; echo_i is ignored.
- LISTEN:
  - dp_ce_o = 1.
  - The debounce run counter increments while echo_i = 1 and resets to 0 when echo_i = 0.
  - The block records the ToF value on the first cycle of each run.
  - When the run reaches deb, it goes to DONE with tof = recorded value and timeout = 0.
  - The listen-cycle counter starts at 0 on LISTEN entry. When it reaches tmo − 1 without qualification, the block goes to DONE with tof = all-ones and timeout = 1.
  - If qualification and timeout occur in the same cycle, the echo wins.
- DONE lasts one cycle:
  - done_o = 1;
  - tof_o and timeout_o are updated (they hold until the next DONE);
  - irq_o is set;
  - next state is IDLE.
- abort_i in TX, BLANK or LISTEN: the block enters IDLE next cycle and drops tx_o and dp_ce_o. It produces no done_o and no irq, and tof_o and timeout_o are unchanged.
- abort_i in DONE has no effect.
- irq_o is cleared by irq_clr_i. If set and clear occur in the same cycle, set wins.
- rst_n low mid-measurement: the block is immediately in IDLE and all outputs are 0.

## Timing
- Acceptance: start_i sampled at edge k puts the block in its first active state at k+1, with busy_o = 1 from k+1.
- TX spans 2·burst·half cycles. BLANK spans blank cycles.
- Qualification or timeout at edge m: DONE at m+1 (done_o and the new tof_o visible), IDLE at m+2.
- A new start_i is accepted at m+2 at the earliest.
- Minimum measurement (burst = 0, blank = 0, deb = 1, echo already high) is 3 cycles from acceptance to IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold rst_n low with echo_i = 1 and start_i = 1 → all outputs 0. Release → block stays in IDLE until a new start_i.
- Nominal: half = 4, burst = 3, blank = 10, deb = 2, tmo = 100. Raise echo_i at ToF 40 and hold it → tx_o gives 3 periods of 8 cycles (24 cycles), then dp_ce_o rises at ToF 34. Expect done_o, tof_o = 40, timeout_o = 0, irq_o = 1.
- Debounce: deb = 3; echo pattern 1,1,0,1,1,1 starting at ToF 50 → tof_o = 53.
- Timeout: burst = 1, half = 2, blank = 0, tmo = 20, echo_i = 0 → done_o exactly 20 LISTEN cycles after entry, tof_o = all-ones, timeout_o = 1.
- Abort: abort_i during BLANK → IDLE next cycle, no done_o, tof_o keeps its prior value. A start_i during busy is ignored.
- Edge cases:
  - burst = 0, blank = 0 → LISTEN directly.
  - half = 0 behaves as half = 1.
  - Qualification on the timeout cycle → timeout_o = 0.
  - irq_clr_i coincident with done_o → irq_o stays 1.

Source files
------------

// File: rtl/sonar_ping_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sonar_ping_if                                                   |
// | Brief    : Control/config/result bundle between the register file, the     |
// |            receive datapath and sonar_ping_ctrl.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface sonar_ping_if #(
    parameter int CNT_W   = 32,
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8,
    parameter int DEB_W   = 4
);
    logic               start_i;
    logic               abort_i;
    logic [DIV_W-1:0]   cfg_half_i;
    logic [BURST_W-1:0] cfg_burst_i;
    logic [CNT_W-1:0]   cfg_blank_i;
    logic [CNT_W-1:0]   cfg_tmo_i;
    logic [DEB_W-1:0]   cfg_deb_i;
    logic               echo_i;
    logic               irq_clr_i;
    logic               tx_o;
    logic               dp_ce_o;
    logic               busy_o;
    logic               done_o;
    logic [CNT_W-1:0]   tof_o;
    logic               timeout_o;
    logic               irq_o;

    modport master (
        output start_i, abort_i, cfg_half_i, cfg_burst_i, cfg_blank_i,
               cfg_tmo_i, cfg_deb_i, echo_i, irq_clr_i,
        input  tx_o, dp_ce_o, busy_o, done_o, tof_o, timeout_o, irq_o
    );

    modport slave (
        input  start_i, abort_i, cfg_half_i, cfg_burst_i, cfg_blank_i,
               cfg_tmo_i, cfg_deb_i, echo_i, irq_clr_i,
        output tx_o, dp_ce_o, busy_o, done_o, tof_o, timeout_o, irq_o
    );
endinterface
`default_nettype wire

// File: rtl/sonar_ping_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sonar_ping_ctrl                                                 |
// | Brief    : Sonar measurement sequencer: TX burst, blanking, echo listen    |
// |            with debounce/timeout, time-of-flight capture.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sonar_ping_ctrl #(
    parameter int CNT_W   = 32,
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8,
    parameter int DEB_W   = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    sonar_ping_if.slave      bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TX     = 3'd1,
        S_BLANK  = 3'd2,
        S_LISTEN = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   half_q;
    logic [BURST_W-1:0] burst_q;
    logic [CNT_W-1:0]   blank_q;
    logic [CNT_W-1:0]   tmo_q;
    logic [DEB_W-1:0]   deb_q;
    logic [CNT_W-1:0]   tof_cnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BURST_W:0]   ph_q;
    logic [DEB_W-1:0]   run_q;
    logic [CNT_W-1:0]   rec_q;
    logic               tx_q, dp_ce_q, busy_q, done_q, timeout_q, irq_q;
    logic [CNT_W-1:0]   tof_q;

    logic [CNT_W-1:0]   tof_cnt_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [DEB_W-1:0]   run_d;
    logic               half_end, burst_end, blank_end, tmo_end, qual;

    assign tof_cnt_d = (tof_cnt_q == '1) ? tof_cnt_q : tof_cnt_q + CNT_W'(1);
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign run_d     = run_q + DEB_W'(1);
    assign half_end  = (cnt_q == CNT_W'(half_q) - CNT_W'(1));
    assign burst_end = (ph_q == {burst_q, 1'b0} - (BURST_W+1)'(1));
    assign blank_end = (cnt_q == blank_q - CNT_W'(1));
    assign tmo_end   = (cnt_q == tmo_q - CNT_W'(1));
    assign qual      = bus.echo_i && (run_d == deb_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            half_q    <= '0;
            burst_q   <= '0;
            blank_q   <= '0;
            tmo_q     <= '0;
            deb_q     <= '0;
            tof_cnt_q <= '0;
            cnt_q     <= '0;
            ph_q      <= '0;
            run_q     <= '0;
            rec_q     <= '0;
            tx_q      <= 1'b0;
            dp_ce_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            irq_q     <= 1'b0;
            tof_q     <= '0;
        end else begin
            done_q <= 1'b0;
            irq_q  <= irq_q & ~bus.irq_clr_i;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start_i && !bus.abort_i) begin
                        half_q    <= (bus.cfg_half_i == '0) ? DIV_W'(1) : bus.cfg_half_i;
                        burst_q   <= bus.cfg_burst_i;
                        blank_q   <= bus.cfg_blank_i;
                        tmo_q     <= (bus.cfg_tmo_i == '0) ? CNT_W'(1) : bus.cfg_tmo_i;
                        deb_q     <= (bus.cfg_deb_i == '0) ? DEB_W'(1) : bus.cfg_deb_i;
                        tof_cnt_q <= '0;
                        cnt_q     <= '0;
                        ph_q      <= '0;
                        run_q     <= '0;
                        busy_q    <= 1'b1;
                        if (bus.cfg_burst_i != '0) begin
                            state_q <= S_TX;
                            tx_q    <= 1'b1;
                        end else if (bus.cfg_blank_i != '0) begin
                            state_q <= S_BLANK;
                        end else begin
                            state_q <= S_LISTEN;
                            dp_ce_q <= 1'b1;
                        end
                    end
                end
                S_TX, S_BLANK, S_LISTEN: begin
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        tx_q    <= 1'b0;
                        dp_ce_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        tof_cnt_q <= tof_cnt_d;
                        if (state_q == S_TX) begin
                            if (!half_end) begin
                                cnt_q <= cnt_d;
                            end else if (!burst_end) begin
                                cnt_q <= '0;
                                ph_q  <= ph_q + (BURST_W+1)'(1);
                                tx_q  <= ~tx_q;
                            end else begin
                                cnt_q <= '0;
                                tx_q  <= 1'b0;
                                if (blank_q != '0) begin
                                    state_q <= S_BLANK;
                                end else begin
                                    state_q <= S_LISTEN;
                                    dp_ce_q <= 1'b1;
                                end
                            end
                        end else if (state_q == S_BLANK) begin
                            if (blank_end) begin
                                state_q <= S_LISTEN;
                                cnt_q   <= '0;
                                dp_ce_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_d;
                            end
                        end else begin
                            run_q <= bus.echo_i ? run_d : '0;
                            if (bus.echo_i && run_q == '0) begin
                                rec_q <= tof_cnt_q;
                            end
                            // A qualifying echo on the timeout cycle still counts as a hit.
                            if (qual || tmo_end) begin
                                state_q   <= S_DONE;
                                dp_ce_q   <= 1'b0;
                                done_q    <= 1'b1;
                                irq_q     <= 1'b1;
                                timeout_q <= !qual;
                                tof_q     <= !qual ? '1 : ((run_q == '0) ? tof_cnt_q : rec_q);
                            end else begin
                                cnt_q <= cnt_d;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    irq_q   <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b0;
                    dp_ce_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_o      = tx_q;
    assign bus.dp_ce_o   = dp_ce_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.tof_o     = tof_q;
    assign bus.timeout_o = timeout_q;
    assign bus.irq_o     = irq_q;
endmodule
`default_nettype wire
